// File: rtl/xnor_prbs_pkg.sv
// rtl/xnor_prbs_pkg.sv - shared types and default tap masks for the XNOR PRBS engine
//
// Purpose : checker FSM state encoding and maximal-length XNOR tap masks for
//           LFSR lengths 3..32.
//           A tap mask has bit i set when state[i] feeds the feedback XNOR.
// Ports   : none (package)

package xnor_prbs_pkg;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    SYNC = 2'd1,
    LOCK = 2'd2
  } prbs_state_e;

  // Maximal-length polynomials. Each mask bit (k-1) corresponds to the
  // polynomial term x^k. For example, x^7 + x^6 + 1 gives the mask 7'h60.
  function automatic logic [31:0] default_taps(input int width);
    case (width)
      3:       return 32'h0000_0006;
      4:       return 32'h0000_000C;
      5:       return 32'h0000_0014;
      6:       return 32'h0000_0030;
      7:       return 32'h0000_0060;
      8:       return 32'h0000_00B8;
      9:       return 32'h0000_0110;
      10:      return 32'h0000_0240;
      11:      return 32'h0000_0500;
      12:      return 32'h0000_0829;
      13:      return 32'h0000_100D;
      14:      return 32'h0000_2015;
      15:      return 32'h0000_6000;
      16:      return 32'h0000_D008;
      17:      return 32'h0001_2000;
      18:      return 32'h0002_0400;
      19:      return 32'h0004_0023;
      20:      return 32'h0009_0000;
      21:      return 32'h0014_0000;
      22:      return 32'h0030_0000;
      23:      return 32'h0042_0000;
      24:      return 32'h00E1_0000;
      25:      return 32'h0120_0000;
      26:      return 32'h0200_0023;
      27:      return 32'h0400_0013;
      28:      return 32'h0900_0000;
      29:      return 32'h1400_0000;
      30:      return 32'h2000_0029;
      31:      return 32'h4800_0000;
      32:      return 32'h8020_0003;
      default: return 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/xnor_lfsr_core.sv
// rtl/xnor_lfsr_core.sv - XNOR-feedback Fibonacci LFSR register with seed load
//
// Purpose : holds the LFSR state and computes the XNOR feedback bit.
//           On each shift, the register takes either the feedback bit or the
//           external serial bit.
//           Loading the lockup seed (all ones) is replaced by all zeros.
// Ports   : clk       in  clock, rising edge
//           rst       in  asynchronous active-high reset (state -> 0)
//           load_i    in  load seed_i; has priority over shift_i
//           seed_i    in  WIDTH seed value
//           shift_i   in  advance the register by one bit
//           sel_din_i in  1 = shift in din_i, 0 = shift in feedback
//           din_i     in  external serial bit
//           fb_o      out XNOR feedback of the current state

module xnor_lfsr_core #(
  parameter int               WIDTH = 7,
  parameter logic [WIDTH-1:0] TAPS  = 7'h60
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] seed_i,
  input  logic             shift_i,
  input  logic             sel_din_i,
  input  logic             din_i,
  output logic             fb_o
);

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_d;
  logic             shift_bit;

  // With XNOR feedback the all-zeros state is legal, and all ones is the stuck state.
  assign fb_o      = ~(^(state_q & TAPS));
  assign shift_bit = sel_din_i ? din_i : fb_o;

  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = (seed_i == {WIDTH{1'b1}}) ? '0 : seed_i;
    end else if (shift_i) begin
      state_d = {state_q[WIDTH-2:0], shift_bit};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/xnor_prbs_engine.sv
// rtl/xnor_prbs_engine.sv - XNOR LFSR PRBS generator / self-synchronising checker
//
// Purpose : mode=0 produces a serial PRBS on dout.
//           mode=1 hunts and synchronises to din, then locks, and then counts
//           bit errors against a free-running prediction.
// Ports   : clk      in  clock, rising edge
//           rst      in  asynchronous active-high reset
//           en       in  bit-advance enable
//           mode     in  0 = generate, 1 = check (sampled when en=1)
//           load     in  synchronous seed load, priority over en
//           seed     in  WIDTH seed value
//           din      in  serial data under check
//           dout     out generated serial bit
//           dout_vld out dout valid (one cycle after a generate en cycle)
//           locked   out checker FSM is in LOCK
//           err      out one-cycle pulse on a mismatch while locked
//           err_cnt  out saturating mismatch count
//           err_sat  out err_cnt has reached all ones

module xnor_prbs_engine
  import xnor_prbs_pkg::*;
#(
  parameter int               WIDTH    = 7,
  parameter logic [WIDTH-1:0] TAPS     = WIDTH'(default_taps(WIDTH)),
  parameter int               CNT_W    = 16,
  parameter int               LOCK_CNT = 16,
  parameter int               LOSS_CNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             din,
  output logic             dout,
  output logic             dout_vld,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_sat
);

  // A single sequence counter is enough. Each FSM state uses only one of these
  // counts: fill (HUNT), match (SYNC), or loss (LOCK).
  localparam int SEQ_MAX = (WIDTH > LOCK_CNT) ?
                           ((WIDTH > LOSS_CNT) ? WIDTH : LOSS_CNT) :
                           ((LOCK_CNT > LOSS_CNT) ? LOCK_CNT : LOSS_CNT);
  localparam int SEQ_W   = $clog2(SEQ_MAX + 1);

  localparam logic [SEQ_W-1:0] FILL_LAST  = SEQ_W'(WIDTH - 1);
  localparam logic [SEQ_W-1:0] MATCH_LAST = SEQ_W'(LOCK_CNT - 1);
  localparam logic [SEQ_W-1:0] LOSS_LAST  = SEQ_W'(LOSS_CNT - 1);
  localparam logic [CNT_W-1:0] ERR_MAX    = '1;

  prbs_state_e      fsm_q,     fsm_d;
  logic [SEQ_W-1:0] seq_cnt_q, seq_cnt_d;
  logic             dout_q,    dout_d;
  logic             dout_vld_q, dout_vld_d;
  logic             err_q,     err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             err_sat_q, err_sat_d;

  logic fb;
  logic sel_din;
  logic mismatch;

  // While hunting or syncing, the register follows the line.
  // Once locked, it free-runs so that line errors do not corrupt the prediction.
  assign sel_din  = mode && (fsm_q != LOCK);
  assign mismatch = (din != fb);

  xnor_lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .load_i    (load),
    .seed_i    (seed),
    .shift_i   (en),
    .sel_din_i (sel_din),
    .din_i     (din),
    .fb_o      (fb)
  );

  always_comb begin
    fsm_d      = fsm_q;
    seq_cnt_d  = seq_cnt_q;
    dout_d     = dout_q;
    dout_vld_d = 1'b0;
    err_d      = 1'b0;
    err_cnt_d  = err_cnt_q;
    err_sat_d  = err_sat_q;

    if (load) begin
      fsm_d     = HUNT;
      seq_cnt_d = '0;
      err_cnt_d = '0;
      err_sat_d = 1'b0;
    end else if (en) begin
      if (!mode) begin
        // The checker is parked in HUNT while generating.
        // Switching back to check mode therefore always restarts acquisition.
        dout_d     = fb;
        dout_vld_d = 1'b1;
        fsm_d      = HUNT;
        seq_cnt_d  = '0;
      end else begin
        case (fsm_q)
          HUNT: begin
            if (seq_cnt_q == FILL_LAST) begin
              fsm_d     = SYNC;
              seq_cnt_d = '0;
            end else begin
              seq_cnt_d = seq_cnt_q + 1'b1;
            end
          end
          SYNC: begin
            if (mismatch) begin
              seq_cnt_d = '0;
            end else if (seq_cnt_q == MATCH_LAST) begin
              fsm_d     = LOCK;
              seq_cnt_d = '0;
            end else begin
              seq_cnt_d = seq_cnt_q + 1'b1;
            end
          end
          LOCK: begin
            if (mismatch) begin
              err_d = 1'b1;
              if (err_cnt_q != ERR_MAX) begin
                err_cnt_d = err_cnt_q + 1'b1;
              end
              err_sat_d = (err_cnt_d == ERR_MAX);
              if (seq_cnt_q == LOSS_LAST) begin
                fsm_d     = HUNT;
                seq_cnt_d = '0;
              end else begin
                seq_cnt_d = seq_cnt_q + 1'b1;
              end
            end else begin
              seq_cnt_d = '0;
            end
          end
          default: begin
            fsm_d     = HUNT;
            seq_cnt_d = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q      <= HUNT;
      seq_cnt_q  <= '0;
      dout_q     <= 1'b0;
      dout_vld_q <= 1'b0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
      err_sat_q  <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      seq_cnt_q  <= seq_cnt_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
      err_sat_q  <= err_sat_d;
    end
  end

  assign dout     = dout_q;
  assign dout_vld = dout_vld_q;
  assign locked   = (fsm_q == LOCK);
  assign err      = err_q;
  assign err_cnt  = err_cnt_q;
  assign err_sat  = err_sat_q;

endmodule

// File: doc/xnor_prbs_engine.md
Name: xnor_prbs_engine

Overview:
Parametrised PRBS generator/checker built on an XNOR-feedback Fibonacci LFSR. It is the sequential successor to the team's single-bit XNOR gate. In generate mode it emits a serial pseudo-random stream. In check mode it self-synchronises to an incoming stream, declares lock, and counts bit errors. It serves as a link/BIST utility between serial test sources and sinks.

Parameters:
WIDTH, 7, LFSR length in bits (3..32)
TAPS, 7'h60, tap mask; bit i set means state[i] feeds the XNOR (default x^7+x^6+1)
CNT_W, 16, error counter width
LOCK_CNT, 16, consecutive matching bits in SYNC required to reach LOCK
LOSS_CNT, 4, consecutive mismatches in LOCK that force return to HUNT

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
en  in  1  bit-advance enable; nothing advances when low
mode  in  1  0 = generate, 1 = check; sampled only when en=1
load  in  1  synchronous seed load; priority over en
seed  in  WIDTH  seed value for load
din  in  1  serial data under check, valid when en=1
dout  out  1  generated serial bit
dout_vld  out  1  dout valid, one cycle after an en=1 cycle in generate mode
locked  out  1  high while checker FSM is in LOCK
err  out  1  one-cycle pulse on a mismatch in LOCK
err_cnt  out  CNT_W  saturating mismatch count
err_sat  out  1  high once err_cnt reaches all-ones

Behaviour:
- Reset, async: state=0, dout=0, dout_vld=0, FSM=HUNT, locked=0, err=0, err_cnt=0, err_sat=0, internal counters=0.
- Feedback: fb = NOT(XOR of state[i] for all i with TAPS[i]=1). The all-zeros state is legal. The all-ones state is the lockup state.
- load=1: state <= seed, except seed all-ones, which is replaced by all-zeros. Also FSM <= HUNT, err_cnt <= 0, err_sat <= 0, counters <= 0, dout_vld <= 0.
- Generate (mode=0, en=1): state <= {state[WIDTH-2:0], fb}, dout <= fb, dout_vld <= 1. With en=0, dout_vld <= 0 and dout holds. Latency is one clock from the en cycle to dout.
- Check (mode=1, en=1) FSM:
  - HUNT: state <= {state[WIDTH-2:0], din}; fill counter increments. When it reaches WIDTH, go to SYNC with match counter=0.
  - SYNC: compare din with fb; state still shifts in din (self-sync). On match, match counter increments; on reaching LOCK_CNT go to LOCK. On mismatch, match counter <= 0 and the FSM stays in SYNC.
  - LOCK: state shifts in fb, not din (free-running prediction). On mismatch, err=1 for that cycle, err_cnt increments unless saturated, and the loss counter increments. On match, loss counter <= 0. When the loss counter reaches LOSS_CNT, go to HUNT (counters cleared, err_cnt kept). locked is registered and equals (FSM==LOCK).
- err_cnt saturates at 2^CNT_W-1; err_sat is set in the same cycle it saturates. err_cnt clears only on rst or load.
- If mode changes while running, the FSM goes to HUNT on the next en cycle. err_cnt is kept and the LFSR state is kept.
- en=0 freezes all state. err is 0 in any cycle without en.
- rst asserted mid-stream resets immediately, regardless of clk.

Decomposition:
- Package xnor_prbs_pkg: FSM state enum (HUNT, SYNC, LOCK) and the default TAPS constants per WIDTH (3..32 maximal-length polynomials).
- Sub-module xnor_lfsr_core: WIDTH/TAPS register, fb computation, shift input mux (fb/din), and seed load with lockup guard.
- The top level holds the FSM, counters and outputs.

Test Plan:
- WIDTH=4, TAPS=4'hC, load seed=0, mode=0, en=1 for 15 cycles -> dout = 1,1,1,0,1,1,0,... The state returns to 0000 after exactly 15 bits, and dout_vld is high from cycle 2.
- Load seed=all-ones, generate -> state reads 0, and the first dout=1 (no lockup).
- Generator looped to checker (same params, different seeds), en=1 -> HUNT for WIDTH bits, SYNC for LOCK_CNT bits, locked=1 at bit WIDTH+LOCK_CNT; err_cnt stays 0.
- While locked, flip 3 isolated din bits -> three err pulses, err_cnt=3, locked stays 1.
- While locked, flip LOSS_CNT consecutive bits -> locked drops after the 4th error, err_cnt=4, then relock after WIDTH+LOCK_CNT good bits.
- CNT_W=3 with continuous errors -> err_cnt stops at 7 and err_sat=1. Assert rst mid-stream -> all outputs 0 in the same cycle.
